// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, widths, fetch payload and fetch status encoding.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned OP_W    = 6;

    localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OP_W-1:0] OP_AND   = 6'b000010;
    localparam logic [OP_W-1:0] OP_OR    = 6'b000011;
    localparam logic [OP_W-1:0] OP_SLT   = 6'b000100;
    localparam logic [OP_W-1:0] OP_MUL   = 6'b000101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b001000;
    localparam logic [OP_W-1:0] OP_SW    = 6'b001001;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_SUBI  = 6'b001011;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_BNEQZ = 6'b001101;
    localparam logic [OP_W-1:0] OP_BEQZ  = 6'b001110;
    localparam logic [OP_W-1:0] OP_JUMP  = 6'b001111;
    localparam logic [OP_W-1:0] OP_HLT   = 6'b111111;

    // Entry handed to decode: instruction plus the address of the next word.
    typedef struct packed {
        logic [INSTR_W-1:0] ir;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FS_RUN,
        FS_FULL,
        FS_DRAIN,
        FS_HALT
    } fetch_state_e;

    function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OP_W] == OP_HLT;
    endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Fetch unit bundle: instruction memory request/response, decode handshake and redirect.
interface mips_fetch_unit_if;
    import mips_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_ir;
    logic [ADDR_W-1:0]  if_pc;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halted;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_valid, if_ir, if_pc,
        input  if_ready, redirect_valid, redirect_pc,
        output halted
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_ir, if_pc,
        output if_ready, redirect_valid, redirect_pc,
        input  halted
    );

endinterface

// File: rtl/mips_prefetch_fifo.sv
// Synchronous FIFO with flush and a registered head word; accepts push+pop while full.
module mips_prefetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_next;
    logic             do_pop;
    logic             do_push;

    assign full    = count == CNT_W'(DEPTH);
    assign empty   = count == '0;
    assign rd_next = rd_ptr + PTR_W'(1);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Head is refreshed from the incoming word or the next stored entry.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            if (do_push && (empty || (count == CNT_W'(1) && do_pop))) begin
                head <= wdata;
            end else if (do_pop && count > CNT_W'(1)) begin
                head <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch: PC ownership, capped prefetch into a queue, redirect flush and HLT stop.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk1,
    input  logic              rst,
    mips_fetch_unit_if.master io
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_e      state_q;
    fetch_state_e      state_n;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_n;
    logic [CNT_W-1:0]  outstanding_q;
    logic [CNT_W-1:0]  outstanding_n;
    logic [CNT_W-1:0]  drop_q;
    logic [CNT_W-1:0]  drop_n;
    logic [OCC_W-1:0]  occ_n;
    logic              cap_n;

    fetch_entry_t      q_wdata;
    fetch_entry_t      q_head;
    logic [CNT_W-1:0]  q_count;
    logic              q_full;
    logic              q_empty;
    logic [ADDR_W-1:0] a_head;
    logic [CNT_W-1:0]  a_count;
    logic              a_full;
    logic              a_empty;

    logic              halted;
    logic              occ_ok;
    logic              acc;
    logic              rsp;
    logic              deq;
    logic              drop;
    logic              enq;
    logic              hlt_enq;

    assign halted = state_q == FS_HALT;
    assign occ_ok = (OCC_W'(q_count) + OCC_W'(outstanding_q)) < OCC_W'(DEPTH);

    // The FIFO full terms are implied by occ_ok; they only guard against overflow.
    assign io.imem_req_valid = !rst && !halted && !io.redirect_valid && occ_ok && !q_full && !a_full;
    assign io.imem_req_addr  = pc_q;
    assign io.if_valid       = !q_empty;
    assign io.if_ir          = q_head.ir;
    assign io.if_pc          = q_head.pc;
    assign io.halted         = halted;

    assign acc     = io.imem_req_valid && io.imem_req_ready;
    assign rsp     = io.imem_rsp_valid;
    assign deq     = io.if_valid && io.if_ready;
    assign drop    = rsp && (io.redirect_valid || drop_q != '0);
    assign enq     = rsp && !drop && !a_empty;
    assign hlt_enq = enq && is_hlt(io.imem_rsp_data);

    assign q_wdata = '{ir: io.imem_rsp_data, pc: a_head + 32'd1};

    mips_prefetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_entry_q (
        .clk   (clk1),
        .rst   (rst),
        .flush (io.redirect_valid),
        .push  (enq),
        .wdata (q_wdata),
        .pop   (deq),
        .head  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    mips_prefetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_addr_q (
        .clk   (clk1),
        .rst   (rst),
        .flush (io.redirect_valid),
        .push  (acc),
        .wdata (pc_q),
        .pop   (enq),
        .head  (a_head),
        .count (a_count),
        .full  (a_full),
        .empty (a_empty)
    );

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q       <= FS_RUN;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_n;
            pc_q          <= pc_n;
            outstanding_q <= outstanding_n;
            drop_q        <= drop_n;
        end
    end

    // Next PC, in-flight bookkeeping and fetch status.
    always_comb begin
        pc_n          = pc_q;
        outstanding_n = outstanding_q + CNT_W'(acc) - CNT_W'(rsp);
        drop_n        = drop_q;
        state_n       = state_q;
        occ_n         = OCC_W'(q_count) + OCC_W'(enq) - OCC_W'(deq) + OCC_W'(outstanding_n);
        cap_n         = occ_n >= OCC_W'(DEPTH);

        if (acc) begin
            pc_n = pc_q + 32'd1;
        end
        if (io.redirect_valid) begin
            pc_n   = io.redirect_pc;
            drop_n = outstanding_n;
        end else if (rsp && drop_q != '0) begin
            drop_n = drop_q - CNT_W'(1);
        end

        if (io.redirect_valid) begin
            state_n = (drop_n != '0) ? FS_DRAIN : FS_RUN;
        end else if (hlt_enq) begin
            state_n = FS_HALT;
        end else begin
            case (state_q)
                FS_HALT: state_n = FS_HALT;
                default: state_n = (drop_n != '0) ? FS_DRAIN : (cap_n ? FS_FULL : FS_RUN);
            endcase
        end
    end

    // Every in-flight fetch is either stale (to be dropped) or paired with a recorded address.
    always_ff @(posedge clk1) begin
        if (!rst) begin
            assert (CNT_W'(drop_q + a_count) == outstanding_q);
        end
    end

endmodule
